// File: rtl/serial_ripple_subtractor.sv
// Bit-serial two's-complement subtractor computing {Bout, D} = A - B - Bin.
// One full-subtractor cell is reused over WIDTH clocks, LSB first.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic [WIDTH:0]   diff
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             load_s;
  logic             finish_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       fs_s;
  logic             d_bit_s;
  logic             br_nxt_s;

  // Returns {borrow_out, difference} for one bit position.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    logic d;
    logic bo;
    d  = a ^ b ^ br;
    bo = (~a & b) | (~(a ^ b) & br);
    return {bo, d};
  endfunction

  assign fs_s     = full_sub(a_sh_r[0], b_sh_r[0], br_r);
  assign d_bit_s  = fs_s[0];
  assign br_nxt_s = fs_s[1];
  assign diff     = {Bout, D};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start is honoured only while idle.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST) begin
          state_nxt_s = IDLE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, bit-serial shifting and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      br_r     <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      D        <= '0;
      Bout     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_s) begin
        a_sh_r   <= A;
        b_sh_r   <= B;
        br_r     <= Bin;
        res_sh_r <= '0;
        cnt_r    <= '0;
        busy     <= 1'b1;
      end else if (state_r == SHIFT) begin
        a_sh_r   <= a_sh_r >> 1;
        b_sh_r   <= b_sh_r >> 1;
        br_r     <= br_nxt_s;
        res_sh_r <= {d_bit_s, res_sh_r[WIDTH-1:1]};
        cnt_r    <= cnt_r + CW'(1);
        // Outputs hold the previous result until the final bit is known.
        if (finish_s) begin
          D     <= {d_bit_s, res_sh_r[WIDTH-1:1]};
          Bout  <= br_nxt_s;
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt_r <= '0;
        end
      end
    end
  end

endmodule
